wb_regfile: RTL

Write-back stage and integer register file for the 5-stage RV32 pipeline. Consumes the MEM/WB pipeline-register outputs, selects the write-back value, and commits it to a 32 x 32-bit register file. Provides two combinational read ports to the decode stage, with same-cycle write-through bypass, and counts retired instructions. Sits between the MEM/WB register and ID.

---
 rtl/wb_regfile.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: RV32 write-back stage, 32x32 integer register file with
// same-cycle write-through bypass on two read ports, and retired-instruction
// counter.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   PC_in                PC of the instruction in WB
//   rd_in                destination register index
//   alures_in            ALU result
//   read_data_in         load data from memory
//   RegWrite_in          register write enable from control
//   WDSel_in             write-data select (00 ALU, 01 mem, 10 PC+4, 11 zero)
//   valid_in             WB slot holds a real instruction
//   rs1_addr, rs2_addr   read port indices
//   rs1_data, rs2_data   read port data (combinational)
//   wb_we, wb_rd         effective write enable / index (to forwarding unit)
//   wb_data              selected write-back value (to forwarding unit)
//   instret              retired-instruction count
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [XLEN-1:0]  PC_in,
    input  logic [4:0]       rd_in,
    input  logic [XLEN-1:0]  alures_in,
    input  logic [XLEN-1:0]  read_data_in,
    input  logic             RegWrite_in,
    input  logic [1:0]       WDSel_in,
    input  logic             valid_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret
);

    logic [XLEN-1:0]  regs_q [32];
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    // Write-back value select; valid_in does not gate the mux itself.
    always_comb begin
        wb_data = '0;
        unique case (WDSel_in)
            2'b00:   wb_data = alures_in;
            2'b01:   wb_data = read_data_in;
            2'b10:   wb_data = PC_in + XLEN'(4);
            default: wb_data = '0;
        endcase
    end

    // x0 is hardwired: a write to index 0 is not an effective write.
    assign wb_we = RegWrite_in & valid_in & (rd_in != 5'd0);
    assign wb_rd = wb_we ? rd_in : 5'd0;

    // Entry 0 is reset and never written; reads of 0 bypass it anyway.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[rd_in] <= wb_data;
        end
    end

    // Read port 1: zero index first, then same-cycle bypass, then storage.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wb_we && (rs1_addr == rd_in)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wb_we && (rs2_addr == rd_in)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    // Every valid WB slot retires, whether or not it writes a register.
    // Natural modular wrap at 2^CNT_W.
    always_comb begin
        instret_d = instret_q;
        if (valid_in) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule
